wav_sample_unpacker: RTL and testbench
======================================

WAV_SAMPLE_UNPACKER -- requirements
Module: wav_sample_unpacker

Interface
REQ-001 SHALL have port CLK  input  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port NRESET  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port I_SOF  input  1  start-of-file marker, valid only with I_DV=1.
REQ-004 SHALL have port I_DV  input  1  input byte valid strobe.
REQ-005 SHALL have port DI  input  8  file byte, in file order.
REQ-006 SHALL have port H_DV  output  1  header byte valid, for pass-through to the file writer.
REQ-007 SHALL have port HD  output  8  header byte copy.
REQ-008 SHALL have port O_DV  output  1  sample valid; drives the filter's I_DV.
REQ-009 SHALL have port DO  output  16  signed PCM sample; drives the filter's DI.
REQ-010 SHALL have port O_EOF  output  1  one-cycle pulse when the data chunk is complete.
REQ-011 SHALL have port O_ERR  output  1  sticky unsupported-format flag, cleared by I_SOF or reset.

Function
REQ-012 SHALL implement states IDLE, HDR, L_LO, L_HI, R_LO, R_HI, DONE, ERR; a byte is accepted only on cycles with I_DV=1.
REQ-013 SHALL move from any state to HDR with header index 0 on an accepted byte with I_SOF=1; that byte counts as header byte 0.
REQ-014 SHALL ignore accepted bytes with I_SOF=0 in IDLE, DONE and ERR.
REQ-015 SHALL in HDR count bytes 0..43, register H_DV=1 and HD=DI one cycle after each header byte, and hold H_DV=0 otherwise.
REQ-016 SHALL capture NumChannels from bytes 22-23, BitsPerSample from bytes 34-35 and data size from bytes 40-43 (32-bit unsigned), all little-endian.
REQ-017 SHALL on byte 43 go to ERR when BitsPerSample!=16 or NumChannels is unsupported, to DONE when data size is 0, else to L_LO.
REQ-018 SHALL decrement the remaining-byte counter once per accepted data byte.
REQ-019 SHALL take the low byte in L_LO/R_LO and the high byte in L_HI/R_HI; L_HI goes to R_LO for 2 channels, else back to L_LO.
REQ-020 SHALL assert O_DV for exactly one cycle, registered one cycle after the sample's last byte is accepted, with DO={hi,lo}.
REQ-021 SHALL go to DONE and pulse O_EOF one cycle after the byte that brings the remaining count to 0, whatever the state.
REQ-022 SHALL drop a trailing incomplete sample without asserting O_DV.
REQ-023 SHALL keep DO holding its last value while O_DV=0.
REQ-024 SHALL set O_ERR one cycle after entering ERR and hold it until reset or I_SOF.

Reset
REQ-025 SHALL on NRESET=0 immediately force state IDLE, all counters 0, and H_DV, HD, O_DV, DO, O_EOF, O_ERR to 0.
REQ-026 SHALL when reset occurs mid-file discard the partial sample and resume only on the next I_SOF.

Configuration
REQ-027 SHALL, with STEREO_DOWNMIX_EN defined, accept NumChannels 1 or 2; for 2 channels it emits one sample per L/R pair, DO=(L+R)>>>1 computed in 17-bit signed arithmetic, with O_DV after R_HI only.
REQ-028 SHALL, without STEREO_DOWNMIX_EN, accept only NumChannels=1, treat 2 as an error (ERR), and never enter R_LO/R_HI.

Verification
REQ-029 SHALL pass: mono header (ch=1, bits=16, size=4) then bytes 34 12 CD AB -> O_DV twice with DO=0x1234 then 0xABCD, then O_EOF one cycle after the last byte.
REQ-030 SHALL pass: 44 header bytes -> 44 H_DV pulses with HD equal to the input bytes, and no O_DV.
REQ-031 SHALL pass (macro on): stereo, size=4, bytes 00 10 00 30 -> one O_DV with DO=0x2000; bytes FF FF 01 00 -> DO=0x0000.
REQ-032 SHALL pass: header with bits=8 -> O_ERR=1, data bytes produce no O_DV; a new I_SOF byte clears O_ERR.
REQ-033 SHALL pass: mono, size=3, bytes 01 00 02 -> one O_DV with DO=0x0001, O_EOF, and no second sample.
REQ-034 SHALL pass: NRESET low after the low byte of a sample -> all outputs 0; bytes without I_SOF ignored until the next I_SOF.

Source files
------------

// File: rtl/wav_sample_unpacker.sv
// WAV byte-stream unpacker: forwards the 44-byte header, then assembles 16-bit PCM samples.
// Optional build macro STEREO_DOWNMIX_EN adds 2-channel input with an (L+R)>>>1 downmix.
module wav_sample_unpacker (
    input  logic        CLK,
    input  logic        NRESET,
    input  logic        I_SOF,
    input  logic        I_DV,
    input  logic [7:0]  DI,
    output logic        H_DV,
    output logic [7:0]  HD,
    output logic        O_DV,
    output logic [15:0] DO,
    output logic        O_EOF,
    output logic        O_ERR
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SIZE_W = 32;
    localparam int unsigned FLD_W  = 16;
    localparam int unsigned SMP_W  = 16;

    localparam logic [IDX_W-1:0] OFS_CH_LO   = IDX_W'(22);
    localparam logic [IDX_W-1:0] OFS_CH_HI   = IDX_W'(23);
    localparam logic [IDX_W-1:0] OFS_BITS_LO = IDX_W'(34);
    localparam logic [IDX_W-1:0] OFS_BITS_HI = IDX_W'(35);
    localparam logic [IDX_W-1:0] OFS_SIZE_0  = IDX_W'(40);
    localparam logic [IDX_W-1:0] OFS_SIZE_1  = IDX_W'(41);
    localparam logic [IDX_W-1:0] OFS_SIZE_2  = IDX_W'(42);
    localparam logic [IDX_W-1:0] OFS_LAST    = IDX_W'(43);

    typedef enum logic [2:0] {
        IDLE, HDR, L_LO, L_HI, R_LO, R_HI, DONE, ERR
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    hdr_idx, idx_nxt;
    logic [FLD_W-1:0]    num_ch, ch_nxt;
    logic [FLD_W-1:0]    bits_ps, bits_nxt;
    logic [SIZE_W-1:0]   rem, rem_nxt;
    logic [7:0]          lo_byte, lo_nxt;
    logic                h_dv_nxt, o_dv_nxt, eof_nxt, err_nxt;
    logic [7:0]          hd_nxt;
    logic [SMP_W-1:0]    do_nxt;
    logic                data_byte;
    logic                ch_ok;

`ifdef STEREO_DOWNMIX_EN
    logic [SMP_W-1:0]    left_smp, left_nxt;
    logic signed [SMP_W:0] mix_sum;
    logic                stereo;

    assign stereo = (num_ch == FLD_W'(2));
    assign ch_ok  = (num_ch == FLD_W'(1)) || stereo;
`else
    assign ch_ok  = (num_ch == FLD_W'(1));
`endif

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge CLK or negedge NRESET) begin
        if (!NRESET) begin
            state   <= IDLE;
            hdr_idx <= '0;
            num_ch  <= '0;
            bits_ps <= '0;
            rem     <= '0;
            lo_byte <= '0;
`ifdef STEREO_DOWNMIX_EN
            left_smp <= '0;
`endif
            H_DV    <= 1'b0;
            HD      <= '0;
            O_DV    <= 1'b0;
            DO      <= '0;
            O_EOF   <= 1'b0;
            O_ERR   <= 1'b0;
        end else begin
            state   <= state_nxt;
            hdr_idx <= idx_nxt;
            num_ch  <= ch_nxt;
            bits_ps <= bits_nxt;
            rem     <= rem_nxt;
            lo_byte <= lo_nxt;
`ifdef STEREO_DOWNMIX_EN
            left_smp <= left_nxt;
`endif
            H_DV    <= h_dv_nxt;
            HD      <= hd_nxt;
            O_DV    <= o_dv_nxt;
            DO      <= do_nxt;
            O_EOF   <= eof_nxt;
            O_ERR   <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        idx_nxt   = hdr_idx;
        ch_nxt    = num_ch;
        bits_nxt  = bits_ps;
        rem_nxt   = rem;
        lo_nxt    = lo_byte;
        h_dv_nxt  = 1'b0;
        hd_nxt    = HD;
        o_dv_nxt  = 1'b0;
        do_nxt    = DO;
        eof_nxt   = 1'b0;
        err_nxt   = O_ERR | (state == ERR);
        data_byte = 1'b0;
`ifdef STEREO_DOWNMIX_EN
        left_nxt  = left_smp;
        mix_sum   = $signed({left_smp[SMP_W-1], left_smp})
                  + $signed({DI[7], DI, lo_byte});
`endif

        if (I_DV) begin
            if (I_SOF) begin
                // The start-of-file byte is itself header byte 0.
                state_nxt = HDR;
                idx_nxt   = IDX_W'(1);
                h_dv_nxt  = 1'b1;
                hd_nxt    = DI;
                err_nxt   = 1'b0;
            end else begin
                case (state)
                    HDR: begin
                        h_dv_nxt = 1'b1;
                        hd_nxt   = DI;
                        idx_nxt  = hdr_idx + IDX_W'(1);
                        case (hdr_idx)
                            OFS_CH_LO:   ch_nxt[7:0]     = DI;
                            OFS_CH_HI:   ch_nxt[15:8]    = DI;
                            OFS_BITS_LO: bits_nxt[7:0]   = DI;
                            OFS_BITS_HI: bits_nxt[15:8]  = DI;
                            OFS_SIZE_0:  rem_nxt[7:0]    = DI;
                            OFS_SIZE_1:  rem_nxt[15:8]   = DI;
                            OFS_SIZE_2:  rem_nxt[23:16]  = DI;
                            OFS_LAST: begin
                                rem_nxt[31:24] = DI;
                                if ((bits_ps != FLD_W'(16)) || !ch_ok)
                                    state_nxt = ERR;
                                else if ({DI, rem[23:0]} == '0)
                                    state_nxt = DONE;
                                else
                                    state_nxt = L_LO;
                            end
                            default: ;
                        endcase
                    end
                    L_LO: begin
                        data_byte = 1'b1;
                        lo_nxt    = DI;
                        state_nxt = L_HI;
                    end
                    L_HI: begin
                        data_byte = 1'b1;
`ifdef STEREO_DOWNMIX_EN
                        if (stereo) begin
                            left_nxt  = {DI, lo_byte};
                            state_nxt = R_LO;
                        end else begin
                            o_dv_nxt  = 1'b1;
                            do_nxt    = {DI, lo_byte};
                            state_nxt = L_LO;
                        end
`else
                        o_dv_nxt  = 1'b1;
                        do_nxt    = {DI, lo_byte};
                        state_nxt = L_LO;
`endif
                    end
`ifdef STEREO_DOWNMIX_EN
                    R_LO: begin
                        data_byte = 1'b1;
                        lo_nxt    = DI;
                        state_nxt = R_HI;
                    end
                    R_HI: begin
                        data_byte = 1'b1;
                        o_dv_nxt  = 1'b1;
                        do_nxt    = SMP_W'(mix_sum >>> 1);
                        state_nxt = L_LO;
                    end
`endif
                    default: ;
                endcase

                // Last data byte ends the chunk regardless of sample alignment.
                if (data_byte) begin
                    rem_nxt = rem - SIZE_W'(1);
                    if (rem == SIZE_W'(1)) begin
                        state_nxt = DONE;
                        eof_nxt   = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wav_sample_unpacker.sv
// Scoreboard bench for wav_sample_unpacker: random and directed WAV files vs. a byte-level model.
module tb_wav_sample_unpacker;

    logic        CLK = 1'b0;
    logic        NRESET;
    logic        I_SOF;
    logic        I_DV;
    logic [7:0]  DI;
    logic        H_DV;
    logic [7:0]  HD;
    logic        O_DV;
    logic [15:0] DO;
    logic        O_EOF;
    logic        O_ERR;

    wav_sample_unpacker dut (
        .CLK(CLK), .NRESET(NRESET), .I_SOF(I_SOF), .I_DV(I_DV), .DI(DI),
        .H_DV(H_DV), .HD(HD), .O_DV(O_DV), .DO(DO), .O_EOF(O_EOF), .O_ERR(O_ERR)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        int unsigned cyc;
    } ev_t;

    ev_t         hq[$];
    ev_t         sq[$];
    int unsigned eq[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] last_do = 16'h0;
    logic [7:0]  dat[$];

`ifdef STEREO_DOWNMIX_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output asserted with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        ev_t e;
        forever begin
            @(negedge CLK);
            if (!NRESET) begin
                last_do = 16'h0;
            end else begin
                if (H_DV) begin
                    if (hq.size() == 0) unexpected("h_dv");
                    else begin
                        e = hq.pop_front();
                        check("hd_value", 32'(HD), 32'(e.val));
                        check("hd_cycle", cyc, e.cyc);
                    end
                end
                if (O_DV) begin
                    if (sq.size() == 0) unexpected("o_dv");
                    else begin
                        e = sq.pop_front();
                        check("do_value", 32'(DO), 32'(e.val));
                        check("do_cycle", cyc, e.cyc);
                    end
                    last_do = DO;
                end else begin
                    check("do_hold", 32'(DO), 32'(last_do));
                end
                if (O_EOF) begin
                    if (eq.size() == 0) unexpected("o_eof");
                    else check("eof_cycle", cyc, eq.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            I_DV  = 1'b0;
            I_SOF = 1'b0;
        end
    endtask

    // Drive one byte; acc is the cycle on which its registered response appears.
    task automatic put(input logic [7:0] b, input logic sof, input int gap, output int unsigned acc);
        idle(gap);
        @(posedge CLK);
        #1;
        I_DV  = 1'b1;
        I_SOF = sof;
        DI    = b;
        acc   = cyc + 1;
    endtask

    // Send a full header followed by the bytes in dat; the model decides what must come out.
    task automatic send_file(input int ch, input int bits, input int size, input int gapmax);
        logic [7:0]  hdr[44];
        logic [31:0] sz;
        logic        sup;
        logic        smp_at[64];
        logic [15:0] val_at[64];
        int          neff;
        int unsigned acc;
        logic signed [15:0] ls, rs;
        int          mix;

        sz = 32'(size);
        for (int i = 0; i < 44; i++) hdr[i] = 8'($urandom);
        hdr[22] = 8'(ch);      hdr[23] = 8'(ch >> 8);
        hdr[34] = 8'(bits);    hdr[35] = 8'(bits >> 8);
        hdr[40] = sz[7:0];     hdr[41] = sz[15:8];
        hdr[42] = sz[23:16];   hdr[43] = sz[31:24];

        sup  = (bits == 16) && ((ch == 1) || (STEREO && ch == 2));
        neff = (dat.size() < size) ? dat.size() : size;
        for (int j = 0; j < 64; j++) begin
            smp_at[j] = 1'b0;
            val_at[j] = 16'h0;
        end
        if (sup) begin
            if (ch == 1) begin
                for (int k = 0; 2 * k + 1 < neff; k++) begin
                    smp_at[2*k+1] = 1'b1;
                    val_at[2*k+1] = {dat[2*k+1], dat[2*k]};
                end
            end else begin
                for (int f = 0; 4 * f + 3 < neff; f++) begin
                    ls  = {dat[4*f+1], dat[4*f]};
                    rs  = {dat[4*f+3], dat[4*f+2]};
                    mix = (int'(ls) + int'(rs)) >>> 1;
                    smp_at[4*f+3] = 1'b1;
                    val_at[4*f+3] = 16'(mix);
                end
            end
        end

        for (int i = 0; i < 44; i++) begin
            put(hdr[i], i == 0, (i == 0) ? 0 : $urandom_range(gapmax, 0), acc);
            hq.push_back('{val: 16'(hdr[i]), cyc: acc});
            if (i == 2) check("o_err_cleared_by_sof", 32'(O_ERR), 32'h0);
        end
        for (int j = 0; j < dat.size(); j++) begin
            put(dat[j], 1'b0, $urandom_range(gapmax, 0), acc);
            if (smp_at[j]) sq.push_back('{val: val_at[j], cyc: acc});
            if (sup && j == size - 1) eq.push_back(acc);
        end
        idle(4);
        check("o_err", 32'(O_ERR), 32'(!sup));
        check("hq_drained", hq.size(), 0);
        check("sq_drained", sq.size(), 0);
        check("eq_drained", eq.size(), 0);
    endtask

    initial begin
        int unsigned acc;
        int ch, bits, size, n;

        NRESET = 1'b0;
        I_DV   = 1'b0;
        I_SOF  = 1'b0;
        DI     = 8'h0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_h_dv",  32'(H_DV),  32'h0);
        check("rst_hd",    32'(HD),    32'h0);
        check("rst_o_dv",  32'(O_DV),  32'h0);
        check("rst_do",    32'(DO),    32'h0);
        check("rst_o_eof", 32'(O_EOF), 32'h0);
        check("rst_o_err", 32'(O_ERR), 32'h0);
        NRESET = 1'b1;
        idle(2);

        // Basic mono file with two samples.
        dat = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        send_file(1, 16, 4, 0);

        // Header only: pass-through with no samples.
        dat = '{};
        send_file(1, 16, 4, 1);

`ifdef STEREO_DOWNMIX_EN
        dat = '{8'h00, 8'h10, 8'h00, 8'h30};
        send_file(2, 16, 4, 0);
        dat = '{8'hFF, 8'hFF, 8'h01, 8'h00};
        send_file(2, 16, 4, 1);
`else
        dat = '{8'h00, 8'h10, 8'h00, 8'h30};
        send_file(2, 16, 4, 0);
`endif

        // Unsupported bit depth, then a clean file clears the error.
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_file(1, 8, 4, 0);

        // Odd size: trailing byte dropped.
        dat = '{8'h01, 8'h00, 8'h02};
        send_file(1, 16, 3, 0);

        // Reset after the low byte of a sample, then stray bytes must be ignored.
        dat = '{8'h34};
        send_file(1, 16, 4, 0);
        NRESET = 1'b0;
        #1;
        check("midrst_h_dv",  32'(H_DV),  32'h0);
        check("midrst_hd",    32'(HD),    32'h0);
        check("midrst_o_dv",  32'(O_DV),  32'h0);
        check("midrst_do",    32'(DO),    32'h0);
        check("midrst_o_eof", 32'(O_EOF), 32'h0);
        check("midrst_o_err", 32'(O_ERR), 32'h0);
        idle(2);
        NRESET = 1'b1;
        put(8'h12, 1'b0, 0, acc);
        put(8'hCD, 1'b0, 0, acc);
        put(8'hAB, 1'b0, 0, acc);
        put(8'h00, 1'b0, 1, acc);
        idle(4);
        dat = '{8'h78, 8'h56};
        send_file(1, 16, 2, 0);

        // Randomized files: channel counts, depths, sizes and truncation/overrun.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(5, 0))
                0:       ch = 2;
                1:       ch = ($urandom_range(1, 0) == 1) ? 3 : 0;
                2:       ch = 2;
                default: ch = 1;
            endcase
            bits = ($urandom_range(4, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 8 : 24) : 16;
            size = $urandom_range(24, 1);
            n    = size + $urandom_range(6, 0) - 3;
            if (n < 0) n = 0;
            dat = '{};
            for (int j = 0; j < n; j++) dat.push_back(8'($urandom));
            send_file(ch, bits, size, $urandom_range(2, 0));
            idle($urandom_range(3, 0));
        end

        idle(5);
        check("final_hq_empty", hq.size(), 0);
        check("final_sq_empty", sq.size(), 0);
        check("final_eq_empty", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
